// File: rtl/ofs_plat_avalon_mem_fiu_banks_tie_off_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ofs_plat_avalon_mem_fiu_banks_tie_off_responder
//  Purpose  : Terminates NUM_BANKS unused FIU-side Avalon-MM banks. It drains
//             write bursts and answers read bursts with fill data so that
//             probing masters never hang. Per-bank statistics counters are
//             built only when OFS_PLAT_TIE_OFF_RESPONDER_STATS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module ofs_plat_avalon_mem_fiu_banks_tie_off_responder #(
    parameter int          NUM_BANKS       = 4,
    parameter int          ADDR_WIDTH      = 27,
    parameter int          DATA_WIDTH      = 512,
    parameter int          BURST_CNT_WIDTH = 7,
    parameter logic [31:0] FILL_PATTERN    = 32'hDEAD_0000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]      avs_address,
    input  logic [NUM_BANKS-1:0]                 avs_read,
    input  logic [NUM_BANKS-1:0]                 avs_write,
    input  logic [NUM_BANKS*BURST_CNT_WIDTH-1:0] avs_burstcount,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]      avs_writedata,
    input  logic [NUM_BANKS*DATA_WIDTH/8-1:0]    avs_byteenable,
    output logic [NUM_BANKS-1:0]                 avs_waitrequest,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]      avs_readdata,
    output logic [NUM_BANKS-1:0]                 avs_readdatavalid,
    output logic [NUM_BANKS*16-1:0]              stat_rd_bursts,
    output logic [NUM_BANKS*16-1:0]              stat_wr_bursts,
    output logic [NUM_BANKS*16-1:0]              stat_violations
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wr   = 2'd1;
    localparam logic [1:0] c_st_rd   = 2'd2;

    localparam logic [DATA_WIDTH-1:0]      c_fill    = {(DATA_WIDTH/32){FILL_PATTERN}};
    localparam logic [DATA_WIDTH-17:0]     c_fill_hi = c_fill[DATA_WIDTH-1:16];
    localparam logic [BURST_CNT_WIDTH-1:0] c_bc_one  = BURST_CNT_WIDTH'(1);
    localparam logic [BURST_CNT_WIDTH-1:0] c_bc_zero = '0;

    // Address, write data and byte enables are accepted but have no effect.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{avs_address, avs_writedata, avs_byteenable};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [1:0]                 r_state,     w_state_nxt;
            logic [BURST_CNT_WIDTH-1:0] r_remaining, w_remaining_nxt;
            logic [BURST_CNT_WIDTH-1:0] r_beat,      w_beat_nxt;
            logic                       r_waitreq,   w_waitreq_nxt;
            logic                       r_rdvalid,   w_rdvalid_nxt;
            logic [DATA_WIDTH-1:0]      r_rddata,    w_rddata_nxt;
            logic [BURST_CNT_WIDTH-1:0] w_bc_raw;
            logic [BURST_CNT_WIDTH-1:0] w_burst;
            logic                       w_read;
            logic                       w_write;
            logic                       w_idle_open;
            logic                       w_wr_accept;
            logic                       w_rd_accept;
            logic                       w_violation;

            assign w_read      = avs_read[gi];
            assign w_write     = avs_write[gi];
            assign w_bc_raw    = avs_burstcount[gi*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
            assign w_burst     = (w_bc_raw == c_bc_zero) ? c_bc_one : w_bc_raw;
            assign w_idle_open = (r_state == c_st_idle) && !r_waitreq;
            assign w_wr_accept = w_idle_open && w_write;
            assign w_rd_accept = w_idle_open && w_read && !w_write;
            // A read is a violation when it collides with an accepted write or
            // arrives in the middle of a write burst; waitrequest is low in both.
            assign w_violation = w_read && !r_waitreq &&
                                 (w_write || (r_state == c_st_wr));

            always_comb begin
                w_state_nxt     = r_state;
                w_remaining_nxt = r_remaining;
                w_beat_nxt      = r_beat;
                w_waitreq_nxt   = 1'b0;
                w_rdvalid_nxt   = 1'b0;
                w_rddata_nxt    = r_rddata;
                case (r_state)
                    c_st_idle: begin
                        if (w_wr_accept) begin
                            if (w_burst != c_bc_one) begin
                                w_state_nxt     = c_st_wr;
                                w_remaining_nxt = w_burst - c_bc_one;
                            end
                        end else if (w_rd_accept) begin
                            // Beat 0 is registered on the accepting edge.
                            w_state_nxt     = c_st_rd;
                            w_remaining_nxt = w_burst - c_bc_one;
                            w_beat_nxt      = c_bc_one;
                            w_waitreq_nxt   = 1'b1;
                            w_rdvalid_nxt   = 1'b1;
                            w_rddata_nxt    = {c_fill_hi, 16'h0000};
                        end
                    end
                    c_st_wr: begin
                        if (w_write) begin
                            if (r_remaining == c_bc_one) begin
                                w_state_nxt = c_st_idle;
                            end
                            w_remaining_nxt = r_remaining - c_bc_one;
                        end
                    end
                    c_st_rd: begin
                        if (r_remaining != c_bc_zero) begin
                            w_waitreq_nxt   = 1'b1;
                            w_rdvalid_nxt   = 1'b1;
                            w_rddata_nxt    = {c_fill_hi, 16'(r_beat)};
                            w_beat_nxt      = r_beat + c_bc_one;
                            w_remaining_nxt = r_remaining - c_bc_one;
                        end else begin
                            w_state_nxt = c_st_idle;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_idle;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state     <= c_st_idle;
                    r_remaining <= '0;
                    r_beat      <= '0;
                    r_waitreq   <= 1'b1;
                    r_rdvalid   <= 1'b0;
                    r_rddata    <= '0;
                end else begin
                    r_state     <= w_state_nxt;
                    r_remaining <= w_remaining_nxt;
                    r_beat      <= w_beat_nxt;
                    r_waitreq   <= w_waitreq_nxt;
                    r_rdvalid   <= w_rdvalid_nxt;
                    r_rddata    <= w_rddata_nxt;
                end
            end

            assign avs_waitrequest[gi]                    = r_waitreq;
            assign avs_readdatavalid[gi]                  = r_rdvalid;
            assign avs_readdata[gi*DATA_WIDTH +: DATA_WIDTH] = r_rddata;

`ifdef OFS_PLAT_TIE_OFF_RESPONDER_STATS_EN
            logic [15:0] r_rd_cnt;
            logic [15:0] r_wr_cnt;
            logic [15:0] r_viol_cnt;

            // Counters stick at all-ones instead of wrapping.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_cnt   <= '0;
                    r_wr_cnt   <= '0;
                    r_viol_cnt <= '0;
                end else begin
                    if (w_rd_accept && (r_rd_cnt != 16'hFFFF)) begin
                        r_rd_cnt <= r_rd_cnt + 16'd1;
                    end
                    if (w_wr_accept && (r_wr_cnt != 16'hFFFF)) begin
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                    end
                    if (w_violation && (r_viol_cnt != 16'hFFFF)) begin
                        r_viol_cnt <= r_viol_cnt + 16'd1;
                    end
                end
            end

            assign stat_rd_bursts[gi*16 +: 16]  = r_rd_cnt;
            assign stat_wr_bursts[gi*16 +: 16]  = r_wr_cnt;
            assign stat_violations[gi*16 +: 16] = r_viol_cnt;
`else
            logic w_unused_stat;
            assign w_unused_stat = w_violation;

            assign stat_rd_bursts[gi*16 +: 16]  = 16'h0000;
            assign stat_wr_bursts[gi*16 +: 16]  = 16'h0000;
            assign stat_violations[gi*16 +: 16] = 16'h0000;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_avalon_mem_fiu_banks_tie_off_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ofs_plat_avalon_mem_fiu_banks_tie_off_responder
//  Purpose  : Self-checking bench for the multi-bank tie-off responder against
//             a cycle-level behavioural model; stats follow
//             OFS_PLAT_TIE_OFF_RESPONDER_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ofs_plat_avalon_mem_fiu_banks_tie_off_responder;

    localparam int          NB   = 4;
    localparam int          AW   = 27;
    localparam int          DW   = 512;
    localparam int          BCW  = 7;
    localparam logic [31:0] FILL = 32'hDEAD_0000;

`ifdef OFS_PLAT_TIE_OFF_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [NB*AW-1:0]    avs_address;
    logic [NB-1:0]       avs_read;
    logic [NB-1:0]       avs_write;
    logic [NB*BCW-1:0]   avs_burstcount;
    logic [NB*DW-1:0]    avs_writedata;
    logic [NB*DW/8-1:0]  avs_byteenable;
    logic [NB-1:0]       avs_waitrequest;
    logic [NB*DW-1:0]    avs_readdata;
    logic [NB-1:0]       avs_readdatavalid;
    logic [NB*16-1:0]    stat_rd_bursts;
    logic [NB*16-1:0]    stat_wr_bursts;
    logic [NB*16-1:0]    stat_violations;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: outputs expected after the most recent edge.
    logic [NB-1:0] m_wait;
    logic [NB-1:0] m_valid;
    logic [DW-1:0] m_data    [NB];
    int            m_wr_left [NB];
    int            m_rd_len  [NB];
    int            m_rd_done [NB];
    int            m_rd_cnt  [NB];
    int            m_wr_cnt  [NB];
    int            m_viol    [NB];

    ofs_plat_avalon_mem_fiu_banks_tie_off_responder #(
        .NUM_BANKS       (NB),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BURST_CNT_WIDTH (BCW),
        .FILL_PATTERN    (FILL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_burstcount    (avs_burstcount),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .stat_rd_bursts    (stat_rd_bursts),
        .stat_wr_bursts    (stat_wr_bursts),
        .stat_violations   (stat_violations)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fill_beat(int beat);
        logic [DW-1:0] d;
        for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = FILL;
        d[15:0] = beat[15:0];
        return d;
    endfunction

    function automatic int sat16(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [15:0] exp_stat(int v);
        return STATS ? v[15:0] : 16'h0000;
    endfunction

    // Applies the responder's rules to the inputs present at this edge.
    task automatic model_update();
        logic rd, wr;
        int   bc;
        for (int b = 0; b < NB; b++) begin
            rd = avs_read[b];
            wr = avs_write[b];
            bc = int'(avs_burstcount[b*BCW +: BCW]);
            if (bc == 0) bc = 1;
            if (reset) begin
                m_wait[b] = 1'b1;  m_valid[b] = 1'b0;  m_data[b] = '0;
                m_wr_left[b] = 0;  m_rd_len[b] = 0;    m_rd_done[b] = 0;
                m_rd_cnt[b] = 0;   m_wr_cnt[b] = 0;    m_viol[b] = 0;
            end else begin
                if (m_wr_left[b] > 0) begin
                    if (rd) m_viol[b] = sat16(m_viol[b] + 1);
                    if (wr) m_wr_left[b] = m_wr_left[b] - 1;
                end else if (!m_wait[b] && wr) begin
                    m_wr_cnt[b] = sat16(m_wr_cnt[b] + 1);
                    if (rd) m_viol[b] = sat16(m_viol[b] + 1);
                    m_wr_left[b] = bc - 1;
                end else if (!m_wait[b] && rd) begin
                    m_rd_cnt[b]  = sat16(m_rd_cnt[b] + 1);
                    m_rd_len[b]  = bc;
                    m_rd_done[b] = 0;
                end
                if (m_rd_done[b] < m_rd_len[b]) begin
                    m_valid[b] = 1'b1;
                    m_wait[b]  = 1'b1;
                    m_data[b]  = fill_beat(m_rd_done[b]);
                    m_rd_done[b] = m_rd_done[b] + 1;
                end else begin
                    m_valid[b] = 1'b0;
                    m_wait[b]  = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        avs_read       = '0;
        avs_write      = '0;
        avs_burstcount = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        avs_address    = '0;
        avs_writedata  = '0;
        avs_byteenable = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (avs_waitrequest !== 4'b1111 || avs_readdatavalid !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hs cyc%0d wait=%b valid=%b, expected 1111/0000", c, avs_waitrequest, avs_readdatavalid);
            end
            n_vec++;
            if (avs_readdata !== '0 || stat_rd_bursts !== '0 || stat_wr_bursts !== '0 || stat_violations !== '0) begin
                n_err++;
                $display("FAIL reset_zero cyc%0d readdata/stats not all zero, rd=%h wr=%h viol=%h", c, stat_rd_bursts, stat_wr_bursts, stat_violations);
            end
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (avs_waitrequest !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release wait=%b, expected 0000", avs_waitrequest);
        end
    endtask

    task automatic test_read_bank0();
        avs_read[0] = 1'b1;
        avs_burstcount[0 +: BCW] = BCW'(4);
        tick();
        avs_read[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (k < 4) begin
                if (avs_readdatavalid[0] !== 1'b1 || avs_waitrequest[0] !== 1'b1 ||
                    avs_readdata[15:0] !== 16'(k) || avs_readdata[31:16] !== 16'hDEAD) begin
                    n_err++;
                    $display("FAIL rd4_beat%0d valid=%b wait=%b data[31:0]=%h, expected 1/1/dead%04h", k, avs_readdatavalid[0], avs_waitrequest[0], avs_readdata[31:0], k);
                end
            end else begin
                if (avs_readdatavalid[0] !== 1'b0 || avs_waitrequest[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL rd4_end valid=%b wait=%b, expected 0/0", avs_readdatavalid[0], avs_waitrequest[0]);
                end
            end
            n_vec++;
            if (avs_readdata[DW-1:0] !== m_data[0]) begin
                n_err++;
                $display("FAIL rd4_data beat%0d got %h exp %h", k, avs_readdata[DW-1:0], m_data[0]);
            end
            tick();
        end
        n_vec++;
        if (stat_rd_bursts[15:0] !== exp_stat(1)) begin
            n_err++;
            $display("FAIL rd4_stat got %0d exp %0d", stat_rd_bursts[15:0], exp_stat(1));
        end
    endtask

    task automatic test_write_concurrent();
        for (int c = 0; c < 12; c++) begin
            avs_write[2] = (c == 0 || c == 1 || c == 3);
            avs_read[2]  = (c == 6);
            avs_burstcount[2*BCW +: BCW] = (c == 6) ? BCW'(1) : BCW'(3);
            avs_read[1]  = ($urandom_range(0, 2) == 0);
            avs_write[1] = ($urandom_range(0, 3) == 0);
            avs_burstcount[1*BCW +: BCW] = BCW'($urandom_range(1, 4));
            tick();
            n_vec++;
            if (avs_readdatavalid[2] !== (c == 6)) begin
                n_err++;
                $display("FAIL wr3_valid cyc%0d got %b exp %b", c, avs_readdatavalid[2], (c == 6));
            end
            for (int b = 0; b < NB; b++) begin
                n_vec++;
                if (avs_waitrequest[b] !== m_wait[b] || avs_readdatavalid[b] !== m_valid[b] ||
                    avs_readdata[b*DW +: DW] !== m_data[b]) begin
                    n_err++;
                    $display("FAIL wr3_model cyc%0d bank%0d wait/valid=%b%b exp %b%b data[31:0]=%h exp %h", c, b, avs_waitrequest[b], avs_readdatavalid[b], m_wait[b], m_valid[b], avs_readdata[b*DW +: 32], m_data[b][31:0]);
                end
            end
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) tick();
        n_vec++;
        if (stat_wr_bursts[2*16 +: 16] !== exp_stat(1) || stat_rd_bursts[2*16 +: 16] !== exp_stat(1)) begin
            n_err++;
            $display("FAIL wr3_stat wr=%0d rd=%0d exp %0d/%0d", stat_wr_bursts[2*16 +: 16], stat_rd_bursts[2*16 +: 16], exp_stat(1), exp_stat(1));
        end
        n_vec++;
        if (stat_rd_bursts[1*16 +: 16] !== exp_stat(m_rd_cnt[1]) || stat_wr_bursts[1*16 +: 16] !== exp_stat(m_wr_cnt[1]) ||
            stat_violations[1*16 +: 16] !== exp_stat(m_viol[1])) begin
            n_err++;
            $display("FAIL bank1_stat rd/wr/viol=%0d/%0d/%0d exp %0d/%0d/%0d", stat_rd_bursts[16 +: 16], stat_wr_bursts[16 +: 16], stat_violations[16 +: 16], exp_stat(m_rd_cnt[1]), exp_stat(m_wr_cnt[1]), exp_stat(m_viol[1]));
        end
    endtask

    task automatic test_rw_collision();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        avs_read[1]  = 1'b1;
        avs_write[1] = 1'b1;
        avs_burstcount[1*BCW +: BCW] = BCW'(1);
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (avs_readdatavalid[1] !== 1'b0 || avs_waitrequest[1] !== 1'b0) begin
                n_err++;
                $display("FAIL rw_hs cyc%0d valid=%b wait=%b exp 0/0", c, avs_readdatavalid[1], avs_waitrequest[1]);
            end
            tick();
        end
        n_vec++;
        if (stat_violations[1*16 +: 16] !== exp_stat(1) || stat_wr_bursts[1*16 +: 16] !== exp_stat(1) ||
            stat_rd_bursts[1*16 +: 16] !== exp_stat(0)) begin
            n_err++;
            $display("FAIL rw_stat viol/wr/rd=%0d/%0d/%0d exp %0d/%0d/0", stat_violations[16 +: 16], stat_wr_bursts[16 +: 16], stat_rd_bursts[16 +: 16], exp_stat(1), exp_stat(1));
        end
    endtask

    task automatic test_reset_mid_burst();
        avs_read[3] = 1'b1;
        avs_burstcount[3*BCW +: BCW] = BCW'(8);
        tick();
        avs_read[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (avs_readdatavalid[3] !== 1'b1 || avs_readdata[3*DW +: 16] !== 16'(k)) begin
                n_err++;
                $display("FAIL rd8_beat%0d valid=%b idx=%0d exp 1/%0d", k, avs_readdatavalid[3], avs_readdata[3*DW +: 16], k);
            end
            if (k < 2) tick();
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if (avs_readdatavalid !== 4'b0000 || avs_waitrequest !== 4'b1111) begin
                n_err++;
                $display("FAIL rd8_reset cyc%0d valid=%b wait=%b exp 0000/1111", c, avs_readdatavalid, avs_waitrequest);
            end
            n_vec++;
            if (stat_rd_bursts !== '0 || stat_wr_bursts !== '0 || stat_violations !== '0) begin
                n_err++;
                $display("FAIL rd8_stats cyc%0d rd=%h wr=%h viol=%h exp 0", c, stat_rd_bursts, stat_wr_bursts, stat_violations);
            end
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (avs_waitrequest !== 4'b0000 || avs_readdatavalid !== 4'b0000) begin
            n_err++;
            $display("FAIL rd8_release wait=%b valid=%b exp 0000/0000", avs_waitrequest, avs_readdatavalid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < NB; b++) begin
                avs_read[b]  = ($urandom_range(0, 2) == 0);
                avs_write[b] = ($urandom_range(0, 2) == 0);
                avs_burstcount[b*BCW +: BCW] = ($urandom_range(0, 9) == 0) ?
                    BCW'($urandom_range(0, 127)) : BCW'($urandom_range(0, 5));
                avs_address[b*AW +: AW] = AW'($urandom);
            end
            for (int w = 0; w < NB*DW/32; w++) avs_writedata[w*32 +: 32] = $urandom;
            avs_byteenable = {(NB*DW/32){$urandom_range(0, 15)}} ;
            tick();
            for (int b = 0; b < NB; b++) begin
                n_vec++;
                if (avs_waitrequest[b] !== m_wait[b] || avs_readdatavalid[b] !== m_valid[b]) begin
                    n_err++;
                    $display("FAIL rand_hs cyc%0d bank%0d wait/valid=%b%b exp %b%b", c, b, avs_waitrequest[b], avs_readdatavalid[b], m_wait[b], m_valid[b]);
                end
                n_vec++;
                if (avs_readdata[b*DW +: DW] !== m_data[b]) begin
                    n_err++;
                    $display("FAIL rand_data cyc%0d bank%0d got[63:0]=%h exp[63:0]=%h", c, b, avs_readdata[b*DW +: 64], m_data[b][63:0]);
                end
                n_vec++;
                if (stat_rd_bursts[b*16 +: 16] !== exp_stat(m_rd_cnt[b]) || stat_wr_bursts[b*16 +: 16] !== exp_stat(m_wr_cnt[b]) ||
                    stat_violations[b*16 +: 16] !== exp_stat(m_viol[b])) begin
                    n_err++;
                    $display("FAIL rand_stat cyc%0d bank%0d rd/wr/viol=%0d/%0d/%0d exp %0d/%0d/%0d", c, b, stat_rd_bursts[b*16 +: 16], stat_wr_bursts[b*16 +: 16], stat_violations[b*16 +: 16], exp_stat(m_rd_cnt[b]), exp_stat(m_wr_cnt[b]), exp_stat(m_viol[b]));
                end
            end
        end
        reset = 1'b0;
        idle_inputs();
        for (int c = 0; c < 140; c++) tick();
    endtask

    task automatic test_back_to_back();
        avs_write[0] = 1'b1;
        avs_burstcount[0 +: BCW] = BCW'(1);
        for (int c = 0; c < 70000; c++) begin
            tick();
            if ((c % 4096) == 0 || (m_wr_cnt[0] >= 65534 && m_wr_cnt[0] <= 65535 && c < 65600)) begin
                n_vec++;
                if (stat_wr_bursts[15:0] !== exp_stat(m_wr_cnt[0]) || avs_waitrequest[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_stat cyc%0d wr=%0d wait=%b exp %0d/0", c, stat_wr_bursts[15:0], avs_waitrequest[0], exp_stat(m_wr_cnt[0]));
                end
            end
        end
        avs_write[0] = 1'b0;
        n_vec++;
        if (stat_wr_bursts[15:0] !== (STATS ? 16'hFFFF : 16'h0000)) begin
            n_err++;
            $display("FAIL b2b_sat wr=%h exp %h", stat_wr_bursts[15:0], (STATS ? 16'hFFFF : 16'h0000));
        end
    endtask

    initial begin
        test_reset();
        test_read_bank0();
        test_write_concurrent();
        test_rw_collision();
        test_reset_mid_burst();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
